// File: rtl/xor_stage_pkg.sv
// Shared definitions for the XOR stage deserializer.
//   XOR_WORD_W_DEF : default output word width
//   out_state_t    : state of the output holding register
package xor_stage_pkg;

    localparam int XOR_WORD_W_DEF = 8;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/xor_bit_deserializer_parity_shift_reg.sv
// Bit collector for the XOR stage deserializer: writes each valid serial bit
// into the next free position of a shift register (LSB first), keeps the
// running even parity, and signals completion when the last bit of a word is
// sampled.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous clear of counter and running parity
//   bit_in       : serial data bit
//   bit_valid    : bit_in is sampled this cycle
//   word_next    : completed word including the current bit (valid with complete)
//   parity_next  : even parity of word_next (valid with complete)
//   complete     : the current bit finishes a word
module parity_shift_reg
    import xor_stage_pkg::*;
#(
    parameter int WORD_W = XOR_WORD_W_DEF,
    parameter int CNT_W  = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [WORD_W-1:0] word_next,
    output logic              parity_next,
    output logic              complete
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              par_q;

    // The word and parity are formed combinationally with the current bit
    // merged in, so the output register can load them on the same edge.
    always_comb begin
        word_next          = shift_q;
        word_next[cnt_q]   = bit_in;
        parity_next        = par_q ^ bit_in;
        complete           = bit_valid && !clr && (cnt_q == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else if (clr) begin
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else if (bit_valid) begin
            shift_q <= word_next;
            if (complete) begin
                cnt_q <= '0;
                par_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                par_q <= parity_next;
            end
        end
    end

endmodule

// File: rtl/xor_bit_deserializer.sv
// Deserializer for the 1-bit output stream of the XOR primitive stage.
// Packs bits LSB first into WORD_W-bit words with even parity and offers each
// word on a valid/ready port. A word completing while the previous one is
// still unaccepted is dropped and sets the sticky OVERRUN flag.
// Optional build macro XOR_DESER_SYNC_CLR_EN adds the SYNC_CLR input, which
// synchronously restarts collection and empties the output register.
// Ports:
//   CLK, RST_N  : clock, asynchronous active-low reset
//   SYNC_CLR    : (XOR_DESER_SYNC_CLR_EN only) synchronous clear
//   BIT_IN      : serial bit, sampled when BIT_VALID=1
//   BIT_VALID   : serial bit qualifier
//   WORD_OUT    : completed word, bit 0 received first
//   PARITY_OUT  : XOR of all WORD_OUT bits
//   WORD_VALID  : WORD_OUT/PARITY_OUT hold an unaccepted word
//   WORD_READY  : consumer accepts when WORD_VALID=1 at a rising edge
//   OVERRUN     : sticky, a completed word was dropped
module xor_bit_deserializer
    import xor_stage_pkg::*;
#(
    parameter int WORD_W = XOR_WORD_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
`ifdef XOR_DESER_SYNC_CLR_EN
    input  logic              SYNC_CLR,
`endif
    input  logic              BIT_IN,
    input  logic              BIT_VALID,
    output logic [WORD_W-1:0] WORD_OUT,
    output logic              PARITY_OUT,
    output logic              WORD_VALID,
    input  logic              WORD_READY,
    output logic              OVERRUN
);

    localparam int CNT_W = $clog2(WORD_W);

    logic              clr;
    logic [WORD_W-1:0] word_next;
    logic              parity_next;
    logic              complete;
    logic              accept;
    out_state_t        state_q;

`ifdef XOR_DESER_SYNC_CLR_EN
    assign clr = SYNC_CLR;
`else
    assign clr = 1'b0;
`endif

    parity_shift_reg #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_collect (
        .clk         (CLK),
        .rst_n       (RST_N),
        .clr         (clr),
        .bit_in      (BIT_IN),
        .bit_valid   (BIT_VALID),
        .word_next   (word_next),
        .parity_next (parity_next),
        .complete    (complete)
    );

    assign accept     = (state_q == OUT_FULL) && WORD_READY;
    assign WORD_VALID = (state_q == OUT_FULL);

    // Output register: clear wins over everything; an accept on the same
    // edge as a completion frees the slot so the new word is not dropped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= OUT_EMPTY;
            WORD_OUT   <= '0;
            PARITY_OUT <= 1'b0;
            OVERRUN    <= 1'b0;
        end else if (clr) begin
            state_q    <= OUT_EMPTY;
            OVERRUN    <= 1'b0;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (complete) begin
                        state_q    <= OUT_FULL;
                        WORD_OUT   <= word_next;
                        PARITY_OUT <= parity_next;
                    end
                end
                OUT_FULL: begin
                    if (complete && accept) begin
                        WORD_OUT   <= word_next;
                        PARITY_OUT <= parity_next;
                    end else if (accept) begin
                        state_q    <= OUT_EMPTY;
                    end else if (complete) begin
                        OVERRUN    <= 1'b1;
                    end
                end
                default: state_q <= OUT_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_bit_deserializer.sv
module tb_xor_bit_deserializer;

    logic       CLK;
    logic       RST_N;
`ifdef XOR_DESER_SYNC_CLR_EN
    logic       SYNC_CLR;
`endif
    logic       BIT_IN;
    logic       BIT_VALID;
    logic [7:0] WORD_OUT;
    logic       PARITY_OUT;
    logic       WORD_VALID;
    logic       WORD_READY;
    logic       OVERRUN;

    int n_checks = 0;
    int n_fail   = 0;

    xor_bit_deserializer #(.WORD_W(8)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
`ifdef XOR_DESER_SYNC_CLR_EN
        .SYNC_CLR   (SYNC_CLR),
`endif
        .BIT_IN     (BIT_IN),
        .BIT_VALID  (BIT_VALID),
        .WORD_OUT   (WORD_OUT),
        .PARITY_OUT (PARITY_OUT),
        .WORD_VALID (WORD_VALID),
        .WORD_READY (WORD_READY),
        .OVERRUN    (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // seq lists bits in the order they are sent, first bit in seq[7]
    typedef struct {
        logic [7:0] seq;
        logic       gap;
        logic [7:0] exp_word;
        logic       exp_par;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // one clock edge; return 1 ns later so samples are away from the edge
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [7:0] seq, input logic gap,
                             input logic rdy_body, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            BIT_IN     = seq[7-i];
            BIT_VALID  = 1'b1;
            WORD_READY = (i == 7) ? rdy_last : rdy_body;
            cycle();
            if (gap && i == 3) begin
                BIT_VALID = 1'b0;
                cycle();
                cycle();
            end
        end
        BIT_VALID  = 1'b0;
        BIT_IN     = 1'b0;
        WORD_READY = rdy_body;
    endtask

    initial begin
        int vcount;

        vecs[0] = '{8'b11100000, 1'b0, 8'h07, 1'b1};
        vecs[1] = '{8'b10000000, 1'b1, 8'h01, 1'b1};
        vecs[2] = '{8'b11111111, 1'b0, 8'hFF, 1'b0};
        vecs[3] = '{8'b00000001, 1'b1, 8'h80, 1'b1};
        vecs[4] = '{8'b01000100, 1'b0, 8'h22, 1'b0};

        RST_N      = 1'b0;
`ifdef XOR_DESER_SYNC_CLR_EN
        SYNC_CLR   = 1'b0;
`endif
        BIT_IN     = 1'b0;
        BIT_VALID  = 1'b0;
        WORD_READY = 1'b0;
        cycle();
        cycle();
        check("reset_word", 32'(WORD_OUT), 32'h0);
        check("reset_parity", 32'(PARITY_OUT), 32'h0);
        check("reset_valid", 32'(WORD_VALID), 32'h0);
        check("reset_overrun", 32'(OVERRUN), 32'h0);
        RST_N = 1'b1;
        cycle();

        // Reset mid-word: partial 5 bits must be discarded
        for (int i = 0; i < 5; i++) begin
            BIT_IN    = 1'b1;
            BIT_VALID = 1'b1;
            cycle();
        end
        BIT_VALID = 1'b0;
        #2 RST_N = 1'b0;
        #1 check("async_reset_valid", 32'(WORD_VALID), 32'h0);
        #2 RST_N = 1'b1;
        cycle();
        vcount = 0;
        WORD_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] s;
            s = 8'b10110010;
            BIT_IN    = s[7-i];
            BIT_VALID = 1'b1;
            cycle();
            if (WORD_VALID) vcount++;
            if (i == 7) begin
                check("midrst_valid", 32'(WORD_VALID), 32'h1);
                check("midrst_word", 32'(WORD_OUT), 32'h4D);
                check("midrst_parity", 32'(PARITY_OUT), 32'h0);
            end
        end
        BIT_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (WORD_VALID) vcount++;
        end
        check("midrst_word_count", 32'(vcount), 32'h1);
        WORD_READY = 1'b0;

        // Table-driven words, some with BIT_VALID gaps
        for (int v = 0; v < 5; v++) begin
            send_word(vecs[v].seq, vecs[v].gap, 1'b0, 1'b0);
            check($sformatf("tbl%0d_valid", v), 32'(WORD_VALID), 32'h1);
            check($sformatf("tbl%0d_word", v), 32'(WORD_OUT), 32'(vecs[v].exp_word));
            check($sformatf("tbl%0d_parity", v), 32'(PARITY_OUT), 32'(vecs[v].exp_par));
            WORD_READY = 1'b1;
            cycle();
            check($sformatf("tbl%0d_accepted", v), 32'(WORD_VALID), 32'h0);
            WORD_READY = 1'b0;
        end

        // Backpressure hold on 0xA5
        send_word(8'b10100101, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check($sformatf("hold%0d_valid", i), 32'(WORD_VALID), 32'h1);
            check($sformatf("hold%0d_word", i), 32'(WORD_OUT), 32'hA5);
        end
        WORD_READY = 1'b1;
        cycle();
        check("hold_accept_valid", 32'(WORD_VALID), 32'h0);
        check("hold_word_kept", 32'(WORD_OUT), 32'hA5);
        WORD_READY = 1'b0;

        // Accept of 0xF0 on the same edge 0x3C completes
        send_word(8'b00001111, 1'b0, 1'b0, 1'b0);
        check("simul_first_word", 32'(WORD_OUT), 32'hF0);
        send_word(8'b00111100, 1'b0, 1'b0, 1'b1);
        check("simul_valid", 32'(WORD_VALID), 32'h1);
        check("simul_word", 32'(WORD_OUT), 32'h3C);
        check("simul_parity", 32'(PARITY_OUT), 32'h0);
        check("simul_overrun", 32'(OVERRUN), 32'h0);
        WORD_READY = 1'b1;
        cycle();
        check("simul_drain", 32'(WORD_VALID), 32'h0);
        WORD_READY = 1'b0;

        // Overrun: 0x11 held, 0x22 dropped
        send_word(8'b10001000, 1'b0, 1'b0, 1'b0);
        check("ovr_first_word", 32'(WORD_OUT), 32'h11);
        check("ovr_before", 32'(OVERRUN), 32'h0);
        send_word(8'b01000100, 1'b0, 1'b0, 1'b0);
        check("ovr_word_kept", 32'(WORD_OUT), 32'h11);
        check("ovr_valid", 32'(WORD_VALID), 32'h1);
        check("ovr_flag", 32'(OVERRUN), 32'h1);
        WORD_READY = 1'b1;
        cycle();
        check("ovr_accept_valid", 32'(WORD_VALID), 32'h0);
        check("ovr_sticky1", 32'(OVERRUN), 32'h1);
        send_word(8'b11100000, 1'b0, 1'b1, 1'b1);
        check("ovr_next_word", 32'(WORD_OUT), 32'h07);
        check("ovr_next_parity", 32'(PARITY_OUT), 32'h1);
        cycle();
        check("ovr_next_accept", 32'(WORD_VALID), 32'h0);
        check("ovr_sticky2", 32'(OVERRUN), 32'h1);
        WORD_READY = 1'b0;

`ifdef XOR_DESER_SYNC_CLR_EN
        // Synchronous clear mid-word while a word is held and OVERRUN set
        send_word(8'b11111111, 1'b0, 1'b0, 1'b0);
        check("clr_pre_valid", 32'(WORD_VALID), 32'h1);
        for (int i = 0; i < 3; i++) begin
            BIT_IN    = 1'b1;
            BIT_VALID = 1'b1;
            cycle();
        end
        SYNC_CLR  = 1'b1;
        BIT_IN    = 1'b1;
        BIT_VALID = 1'b1;
        cycle();
        SYNC_CLR  = 1'b0;
        BIT_VALID = 1'b0;
        check("clr_overrun", 32'(OVERRUN), 32'h0);
        check("clr_valid", 32'(WORD_VALID), 32'h0);
        send_word(8'b10110010, 1'b0, 1'b0, 1'b0);
        check("clr_fresh_valid", 32'(WORD_VALID), 32'h1);
        check("clr_fresh_word", 32'(WORD_OUT), 32'h4D);
        check("clr_fresh_overrun", 32'(OVERRUN), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_bit_deserializer.md
Name: xor_bit_deserializer

Overview:
- Downstream stage of the two-input XOR primitive stage; consumes its 1-bit output stream.
- Packs the stream LSB-first into WORD_W-bit words and computes even parity per word.
- Presents each completed word on a valid/ready output port.
- Flags overrun when a new word completes while the previous one is still unaccepted.

Parameters:
- WORD_W, 8, bits per output word; legal range 2..32.
- CNT_W, $clog2(WORD_W), width of the bit counter; derived, never overridden.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- BIT_IN  input  1  serial data bit from the XOR stage.
- BIT_VALID  input  1  BIT_IN is sampled on each rising CLK where BIT_VALID=1; no backpressure upstream.
- WORD_OUT  output  WORD_W  completed word; bit 0 is the first bit received.
- PARITY_OUT  output  1  XOR of all WORD_OUT bits (even parity), aligned with WORD_OUT.
- WORD_VALID  output  1  WORD_OUT/PARITY_OUT hold a word not yet accepted.
- WORD_READY  input  1  consumer accepts the word when WORD_VALID=1 and WORD_READY=1 at a rising edge.
- OVERRUN  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (RST_N=0, asynchronous): shift register=0, counter=0, running parity=0, WORD_OUT=0, PARITY_OUT=0, WORD_VALID=0, OVERRUN=0. Collection restarts from bit 0 after release; any partial word is lost.
- Collect: each BIT_VALID cycle writes BIT_IN into shift-register position [counter], XORs it into running parity, and increments the counter.
- Completion: occurs when BIT_VALID=1 and counter=WORD_W-1.
  - The counter wraps to 0 and running parity clears.
  - The completed word (including the current bit) and its parity are offered to the output register.
- Latency: WORD_VALID rises on the edge that samples the final bit, i.e. it is visible the cycle after the final bit is presented.
- Output register FSM has two states:
  - EMPTY: WORD_VALID=0.
  - FULL: WORD_VALID=1. WORD_OUT and PARITY_OUT are stable while FULL and unaccepted.
- Transitions:
  - EMPTY + completion -> FULL; load word.
  - FULL + accept, no completion -> EMPTY. WORD_OUT keeps its last value.
  - FULL + accept + completion (same edge) -> FULL; load new word. No overrun.
  - FULL + completion, no accept -> FULL; held word unchanged, new word dropped, OVERRUN<=1.
  - Otherwise the state holds.
- OVERRUN clears only on reset, or via SYNC_CLR when the optional feature is built in.
- Collection never stalls on WORD_READY; BIT_VALID gaps of any length are allowed.

Optional Feature:
- Macro: XOR_DESER_SYNC_CLR_EN.
- Defined:
  - Adds input port SYNC_CLR (1 bit), placed after RST_N.
  - SYNC_CLR=1 at an edge zeroes counter, running parity, WORD_VALID and OVERRUN (FSM -> EMPTY). BIT_IN in that cycle is ignored.
  - SYNC_CLR has priority over completion and accept in the same cycle.
- Undefined: no SYNC_CLR port; only RST_N clears state.

Decomposition:
- Package xor_stage_pkg holds:
  - localparam XOR_WORD_W_DEF=8.
  - Enum out_state_t {OUT_EMPTY, OUT_FULL}.
- One natural sub-module: parity_shift_reg (counter, shift register, running parity, completion pulse).
- The top level holds the output FSM and overrun logic.

Test Plan:
- Reset mid-word: feed 5 bits, pulse RST_N low asynchronously (not clock-aligned), then feed bits 1,0,1,1,0,0,1,0 with WORD_READY=1 -> exactly one word, WORD_OUT=0x4D, PARITY_OUT=0, WORD_VALID high for 1 cycle.
- Parity odd: bits 1,1,1,0,0,0,0,0 -> WORD_OUT=0x07, PARITY_OUT=1.
- Backpressure hold: WORD_READY=0 for 6 cycles after word 0xA5 completes -> WORD_VALID=1 and WORD_OUT=0xA5 stable throughout; accepted on the first cycle WORD_READY=1.
- Simultaneous accept+completion: WORD_READY=1 asserted on the edge where word 2 (0x3C) completes while word 1 (0xF0) is held -> 0xF0 accepted, 0x3C loaded, WORD_VALID stays 1, OVERRUN=0.
- Overrun: hold WORD_READY=0 across two full words 0x11 then 0x22 -> WORD_OUT stays 0x11, OVERRUN=1 and stays 1 after later accepts.
- With XOR_DESER_SYNC_CLR_EN: SYNC_CLR=1 after 3 bits while OVERRUN=1 -> OVERRUN=0, WORD_VALID=0; the next 8 bits form a fresh aligned word.
